// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with an internal oversampling baud generator.
// Each bit is decided by a 2-of-3 majority vote around mid-bit, which rejects short line glitches.
module uart_rx_oversample #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err
);

    // state      | meaning
    // IDLE       | waiting for a high-to-low edge on the synchronized line
    // START      | validating the start bit at mid-bit
    // DATA       | shifting in 8 data bits, LSB first
    // STOP       | sampling the stop bit and publishing the byte
    // WAIT_IDLE  | framing error seen; waiting for the line to return high
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_SMP_A  = SW'(M - 1);
    localparam logic [SW-1:0] S_SMP_B  = SW'(M);
    localparam logic [SW-1:0] S_DECIDE = SW'(M + 1);

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_rx_prev;
    logic [1:0]    r_live;
    logic          r_armed;
    logic [DW-1:0] r_div_cnt;
    logic [SW-1:0] r_s;
    logic [3:0]    r_bit_cnt;
    logic          r_smp_a;
    logic          r_smp_b;
    logic [7:0]    r_shift;

    logic          w_tick;
    logic [SW-1:0] w_s_next;
    logic          w_start_edge;
    logic          w_decide;
    logic          w_wrap;
    logic          w_vote;

    assign w_tick       = (r_div_cnt == DIV_LAST);
    assign w_s_next     = (r_s == S_LAST) ? '0 : r_s + 1'b1;
    // r_armed keeps a line that is already low out of reset from looking like a start edge
    assign w_start_edge = r_armed & r_rx_prev & ~r_sync2;
    assign w_decide     = w_tick & (w_s_next == S_DECIDE);
    assign w_wrap       = w_tick & (r_s == S_LAST);
    assign w_vote       = (r_smp_a & r_smp_b) | (r_smp_a & r_sync2) | (r_smp_b & r_sync2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_live    <= 2'b00;
            r_armed   <= 1'b0;
            r_div_cnt <= '0;
            r_s       <= '0;
            r_bit_cnt <= 4'd0;
            r_smp_a   <= 1'b1;
            r_smp_b   <= 1'b1;
            r_shift   <= 8'h00;
            rx_data   <= 8'h00;
            rx_int    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            r_live    <= {r_live[0], 1'b1};
            if (r_live[1] && r_sync2) begin
                r_armed <= 1'b1;
            end

            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

            if (r_state != ST_IDLE && w_tick) begin
                r_s <= w_s_next;
                if (w_s_next == S_SMP_A) r_smp_a <= r_sync2;
                if (w_s_next == S_SMP_B) r_smp_b <= r_sync2;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= ST_START;
                        r_div_cnt <= '0;
                        r_s       <= '0;
                        r_bit_cnt <= 4'd0;
                    end
                end
                ST_START: begin
                    if (w_decide) begin
                        if (!w_vote) begin
                            rx_int  <= 1'b1;
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift   <= {w_vote, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    if (w_wrap && r_bit_cnt == 4'd8) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leaving mid-stop-bit on a good stop lets a 1-bit-stop back-to-back frame be caught
                    if (w_decide) begin
                        rx_data   <= r_shift;
                        rx_int    <= 1'b0;
                        rx_valid  <= 1'b1;
                        frame_err <= ~w_vote;
                        r_state   <= w_vote ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed and random 8N1 frames checked against a
// frame-level scoreboard (byte, stop-bit validity, latency window).
module tb_uart_rx_oversample;

    localparam int CLK_HZ  = 1600000;
    localparam int BAUD    = 10000;
    localparam int OS      = 16;
    localparam int BIT_CLK = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b0;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       rx_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_rx_oversample #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx(uart_rx),
        .rx_data(rx_data),
        .rx_int(rx_int),
        .rx_valid(rx_valid),
        .frame_err(frame_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_rise = 0;
    int   n_fall = 0;
    int   last_valid_cyc = 0;
    int   last_rise_cyc = 0;
    logic int_prev = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: each rx_valid must match the oldest frame sent
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                int_prev = 1'b0;
                continue;
            end
            if (rx_int && !int_prev) begin
                n_rise++;
                last_rise_cyc = cyc;
            end
            if (!rx_int && int_prev) n_fall++;
            if (frame_err && !rx_valid) check("frame_err_without_valid", 1, 0);
            if (rx_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", int'(rx_data), int'(e.d));
                    check("frame_err", int'(frame_err), int'(e.fe));
                    check("rx_int_falls_with_valid", int'({int_prev, rx_int}), 2);
                    lat = cyc - e.t0;
                    check($sformatf("latency_%0d_in_1510_1535", lat),
                          int'(lat >= 1510 && lat <= 1535), 1);
                end
            end
            int_prev = rx_int;
        end
    end

    // Drives one 8N1 frame from the current negedge. glitch_bit inverts 10 clk around
    // that data bit's centre; abort_bit resets the DUT at the start of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                              input int abort_bit, output int t0);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop, d, 1'b0};
        t0 = cyc;
        if (abort_bit < 0) begin
            e.d  = d;
            e.fe = ~stop;
            e.t0 = cyc;
            exp_q.push_back(e);
        end
        for (int b = 0; b < 10; b++) begin
            if (abort_bit >= 0 && b == abort_bit + 1) begin
                check("rx_int_high_before_reset", int'(rx_int), 1);
                rst_n = 1'b0;
                #1;
                check("midrst_rx_data", int'(rx_data), 0);
                check("midrst_rx_int", int'(rx_int), 0);
                check("midrst_rx_valid", int'(rx_valid), 0);
                check("midrst_frame_err", int'(frame_err), 0);
                uart_rx = 1'b1;
                repeat (50) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            for (int k = 0; k < BIT_CLK; k++) begin
                if (glitch_bit >= 0 && b == glitch_bit + 1 && k >= 75 && k < 85)
                    uart_rx = ~bits[b];
                else
                    uart_rx = bits[b];
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t_a;
        int v0;
        int r0;
        int f0;
        int gap;
        logic [7:0] rd;
        logic rs;
        int gb;

        // Reset with the line held low; no start may be seen until it goes high then low
        uart_rx = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_int", int'(rx_int), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("low_after_reset_no_rise", n_rise, 0);
        check("low_after_reset_no_valid", n_valid, 0);
        uart_rx = 1'b1;
        repeat (50) @(negedge clk);

        // Single frame 0x55
        send_frame(8'h55, 1'b1, -1, -1, t0);
        check("rise_delay_in_60_100",
              int'(last_rise_cyc - t0 >= 60 && last_rise_cyc - t0 <= 100), 1);
        wait_empty(300);
        check("frame1_rises", n_rise, 1);
        check("frame1_falls", n_fall, 1);
        repeat (40) @(negedge clk);

        // Back-to-back 0xA3, 0x00
        f0 = n_fall;
        send_frame(8'hA3, 1'b1, -1, -1, t0);
        t_a = last_valid_cyc;
        send_frame(8'h00, 1'b1, -1, -1, t0);
        wait_empty(300);
        check($sformatf("b2b_spacing_%0d_in_1590_1610", last_valid_cyc - t_a),
              int'(last_valid_cyc - t_a >= 1590 && last_valid_cyc - t_a <= 1610), 1);
        check("b2b_falls", n_fall - f0, 2);
        repeat (40) @(negedge clk);

        // 30-clk glitch on idle line is a false start
        r0 = n_rise;
        v0 = n_valid;
        uart_rx = 1'b0;
        repeat (30) @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_rise", n_rise - r0, 0);
        check("glitch_no_valid", n_valid - v0, 0);
        send_frame(8'h3C, 1'b1, -1, -1, t0);
        wait_empty(300);
        repeat (40) @(negedge clk);

        // 0xF0 with a glitch on bit 2's sample point
        send_frame(8'hF0, 1'b1, 2, -1, t0);
        wait_empty(300);
        repeat (40) @(negedge clk);

        // Framing error then break held low
        v0 = n_valid;
        send_frame(8'h3C, 1'b0, -1, -1, t0);
        uart_rx = 1'b0;
        repeat (2000) @(negedge clk);
        check("break_single_valid", n_valid - v0, 1);
        check("break_rx_int_low", int'(rx_int), 0);
        check("break_rx_data_held", int'(rx_data), 'h3C);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1, -1, -1, t0);
        wait_empty(300);
        repeat (40) @(negedge clk);

        // Reset at data bit 4
        v0 = n_valid;
        send_frame(8'hC3, 1'b1, -1, 4, t0);
        repeat (200) @(negedge clk);
        check("aborted_frame_no_valid", n_valid - v0, 0);
        send_frame(8'h7E, 1'b1, -1, -1, t0);
        wait_empty(300);

        // Random frames, random stop bit, gaps and glitches
        for (int i = 0; i < 10; i++) begin
            rd  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 3) != 0);
            gb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            gap = int'($urandom_range(0, 40));
            if (!rs) gap = gap + 5;
            send_frame(rd, rs, gb, -1, t0);
            repeat (gap) @(negedge clk);
        end
        wait_empty(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
